vga_controller: RTL and testbench



---
 rtl/vga_controller.sv | 122 ++++++++++++
 tb/tb_vga_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_controller.sv
// ---------------------------------------------------------------------------
// vga_controller
//   640x480 @ 60 Hz VGA timing generator and pixel output stage. It runs on
//   the 25 MHz pixel clock, produces the active-low sync pulses and the
//   frame-buffer read address and strobe, and registers the returned BGR
//   pixel onto the 4-bit colour pins. It drives black whenever the address
//   presented on the previous clock was outside the visible window.
//
// Ports
//   vga_clk   in   1   pixel clock; all state changes on its rising edge
//   clrn      in   1   asynchronous active-low reset
//   d_in_BGR  in  12   pixel from memory: [11:8]=B, [7:4]=G, [3:0]=R
//   row_addr  out  9   visible row 0..479 (registered)
//   col_addr  out 10   visible column 0..639 (registered)
//   read      out  1   high while the presented address is visible
//   r, g, b   out  4   colour outputs (registered)
//   hs, vs    out  1   horizontal / vertical sync, active-low
// ---------------------------------------------------------------------------
module vga_controller #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_START  = 143,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [11:0] d_in_BGR,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        read,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs
);

  logic [9:0] r_h_count;
  logic [9:0] r_v_count;
  logic [8:0] r_row;
  logic [9:0] r_col;
  logic       r_read;
  logic       r_hs;
  logic       r_vs;
  logic [3:0] r_r;
  logic [3:0] r_g;
  logic [3:0] r_b;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_h_vis;
  logic       w_v_vis;

  assign w_h_last = (r_h_count == 10'(H_TOTAL - 1));
  assign w_v_last = (r_v_count == 10'(V_TOTAL - 1));
  assign w_h_vis  = (r_h_count >= 10'(H_START)) && (r_h_count < 10'(H_START + H_ACTIVE));
  assign w_v_vis  = (r_v_count >= 10'(V_START)) && (r_v_count < 10'(V_START + V_ACTIVE));

  // Stage 0: free-running line and frame counters
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else begin
      r_h_count <= w_h_last ? 10'd0 : r_h_count + 10'd1;
      if (w_h_last) begin
        r_v_count <= w_v_last ? 10'd0 : r_v_count + 10'd1;
      end
    end
  end

  // Stage 1: sync, address and read strobe, one clock behind the counters.
  // Addresses wrap modulo their width outside the visible window, which keeps
  // them deterministic without extra muxing.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_col  <= '0;
      r_row  <= '0;
      r_read <= 1'b0;
    end else begin
      r_hs   <= (r_h_count >= 10'(H_SYNC));
      r_vs   <= (r_v_count >= 10'(V_SYNC));
      r_col  <= r_h_count - 10'(H_START);
      r_row  <= r_v_count[8:0] - 9'(V_START);
      r_read <= w_h_vis && w_v_vis;
    end
  end

  // Stage 2: pixel capture. Memory returns data one clock after the address,
  // so the strobe registered alongside that address gates the capture.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end else if (r_read) begin
      r_r <= d_in_BGR[3:0];
      r_g <= d_in_BGR[7:4];
      r_b <= d_in_BGR[11:8];
    end else begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end
  end

  assign row_addr = r_row;
  assign col_addr = r_col;
  assign read     = r_read;
  assign hs       = r_hs;
  assign vs       = r_vs;
  assign r        = r_r;
  assign g        = r_g;
  assign b        = r_b;

endmodule

// File: tb/tb_vga_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_controller
//   Bench for vga_controller: a cycle scoreboard fed by an independent timing
//   model, a table of hand-computed checkpoints, and hand-written sequences
//   for sync widths, the visible-line run and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_vga_controller;

  logic        vga_clk = 1'b0;
  logic        clrn = 1'b0;
  logic [11:0] d_in_BGR = 12'hFFF;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        read;
  logic [3:0]  r, g, b;
  logic        hs, vs;

  vga_controller dut (
    .vga_clk  (vga_clk),
    .clrn     (clrn),
    .d_in_BGR (d_in_BGR),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .read     (read),
    .r        (r),
    .g        (g),
    .b        (b),
    .hs       (hs),
    .vs       (vs)
  );

  always #20 vga_clk = ~vga_clk;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       read;
    logic [9:0] col;
    logic [8:0] row;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } out_t;

  typedef struct {
    int          k;      // rising edge number after reset release
    logic [11:0] d;      // pixel driven ahead of that edge
    out_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_edge   = 0;
  int   mh = 0;
  int   mv = 0;
  logic m_read = 1'b0;
  out_t sb_q[$];
  vec_t vecs[$];

  function automatic out_t dut_out();
    out_t o;
    o.hs = hs; o.vs = vs; o.read = read;
    o.col = col_addr; o.row = row_addr;
    o.r = r; o.g = g; o.b = b;
    return o;
  endfunction

  function automatic vec_t mk(int k, logic [11:0] d, logic h, logic v, logic rd,
                              int col, int row, logic [11:0] bgr);
    vec_t t;
    t.k = k; t.d = d;
    t.exp.hs = h; t.exp.vs = v; t.exp.read = rd;
    t.exp.col = 10'(col); t.exp.row = 9'(row);
    t.exp.b = bgr[11:8]; t.exp.g = bgr[7:4]; t.exp.r = bgr[3:0];
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; m_read = 1'b0; n_edge = 0;
    sb_q.delete();
  endtask

  // Called between edges: drives the pixel, predicts the post-edge outputs
  // from the reference timing, then compares after the edge.
  task automatic step(input logic [11:0] d);
    out_t e, a;
    logic h_wrap;
    d_in_BGR = d;
    e.hs   = (mh >= 96);
    e.vs   = (mv >= 2);
    e.col  = 10'(mh - 143);
    e.row  = 9'(mv - 35);
    e.read = (mh >= 143) && (mh <= 782) && (mv >= 35) && (mv <= 514);
    e.r    = m_read ? d[3:0]  : 4'h0;
    e.g    = m_read ? d[7:4]  : 4'h0;
    e.b    = m_read ? d[11:8] : 4'h0;
    sb_q.push_back(e);
    m_read = e.read;
    h_wrap = (mh == 799);
    mh = h_wrap ? 0 : mh + 1;
    if (h_wrap) mv = (mv == 524) ? 0 : mv + 1;
    n_edge++;
    @(posedge vga_clk); #1;
    a = dut_out();
    e = sb_q.pop_front();
    chk($sformatf("sb_edge%0d", n_edge), a, e);
  endtask

  initial begin
    int cnt, lo, hi, run, last_col, hs_rise;

    // checkpoint edge k: outputs reflect pre-edge count k-1 = v*800 + h
    vecs.push_back(mk(1,     12'hFFF, 0, 0, 0, 881,  477, 12'h000));
    vecs.push_back(mk(96,    12'hFFF, 0, 0, 0, 976,  477, 12'h000));
    vecs.push_back(mk(97,    12'hFFF, 1, 0, 0, 977,  477, 12'h000));
    vecs.push_back(mk(1600,  12'hFFF, 1, 0, 0, 656,  478, 12'h000));
    vecs.push_back(mk(1601,  12'hFFF, 0, 1, 0, 881,  479, 12'h000));
    vecs.push_back(mk(28144, 12'hFFF, 1, 1, 1, 0,    0,   12'h000));
    vecs.push_back(mk(28145, 12'hABC, 1, 1, 1, 1,    0,   12'hABC));
    vecs.push_back(mk(28146, 12'h123, 1, 1, 1, 2,    0,   12'h123));
    vecs.push_back(mk(28783, 12'h5A7, 1, 1, 1, 639,  0,   12'h5A7));
    vecs.push_back(mk(28784, 12'hFFF, 1, 1, 0, 640,  0,   12'hFFF));
    vecs.push_back(mk(28785, 12'hFFF, 1, 1, 0, 641,  0,   12'h000));
    vecs.push_back(mk(28801, 12'hFFF, 0, 1, 0, 881,  1,   12'h000));
    vecs.push_back(mk(28943, 12'hFFF, 1, 1, 0, 1023, 1,   12'h000));
    vecs.push_back(mk(28944, 12'hFFF, 1, 1, 1, 0,    1,   12'h000));
    vecs.push_back(mk(28945, 12'h0F0, 1, 1, 1, 1,    1,   12'h0F0));

    // Reset held: everything zero even with a white pixel on the input
    d_in_BGR = 12'hFFF;
    repeat (2) begin
      @(posedge vga_clk); #1;
      chk("reset_state", dut_out(), 64'h0);
    end
    #10 clrn = 1'b1;
    model_reset();

    // Checkpoint table
    foreach (vecs[i]) begin
      while (n_edge < vecs[i].k - 1) step(12'hFFF);
      step(vecs[i].d);
      chk($sformatf("tbl_k%0d", vecs[i].k), dut_out(), vecs[i].exp);
    end

    // Horizontal sync: low width and falling-to-falling period
    cnt = 0;
    while (hs !== 1'b0 && cnt < 1000) begin step(12'hFFF); cnt++; end
    chk("hs_fall_found", (cnt < 1000), 1);
    lo = 0;
    while (hs === 1'b0 && lo < 1000) begin step(12'hFFF); lo++; end
    chk("hs_low_width", lo, 96);
    hi = 0;
    while (hs === 1'b1 && hi < 1000) begin step(12'hFFF); hi++; end
    chk("hs_period", lo + hi, 800);

    // One visible line: read runs 640 clocks with col 0..639
    cnt = 0;
    while (read !== 1'b1 && cnt < 1000) begin step($urandom_range(0, 4095)); cnt++; end
    chk("read_rise_col", col_addr, 0);
    run = 0; last_col = -1;
    while (read === 1'b1 && run < 1000) begin
      last_col = col_addr; run++;
      step($urandom_range(0, 4095));
    end
    chk("read_run_len", run, 640);
    chk("read_last_col", last_col, 639);

    // Asynchronous reset between edges, mid visible line
    cnt = 0;
    while (read !== 1'b1 && cnt < 1000) begin step(12'hFFF); cnt++; end
    repeat (10) step(12'hFFF);
    #5 clrn = 1'b0;
    #1 chk("async_clear", dut_out(), 64'h0);
    @(posedge vga_clk); #1;
    chk("async_hold", dut_out(), 64'h0);
    #10 clrn = 1'b1;
    model_reset();

    // After release: hs rises on edge 97, vs on edge 1601
    hs_rise = 0;
    while (vs !== 1'b1 && n_edge < 2000) begin
      step(12'hFFF);
      if (hs === 1'b1 && hs_rise == 0) hs_rise = n_edge;
    end
    chk("restart_hs_rise", hs_rise, 97);
    chk("restart_vs_rise", n_edge, 1601);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
